// File: rtl/mips_mc_ctrl_pkg.sv
// Shared types and encodings for the multi-cycle MIPS control unit.
package mips_mc_ctrl_pkg;

  localparam int unsigned STATE_W = 4;
  localparam int unsigned OP_W    = 6;

  typedef enum logic [STATE_W-1:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_EXEC_R   = 4'd2,
    S_EXEC_I   = 4'd3,
    S_MEM_ADDR = 4'd4,
    S_MEM_RD   = 4'd5,
    S_MEM_WR   = 4'd6,
    S_WB_R     = 4'd7,
    S_WB_I     = 4'd8,
    S_WB_MEM   = 4'd9,
    S_BRANCH   = 4'd10,
    S_JUMP     = 4'd11,
    S_HALT     = 4'd12
  } state_e;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'h08;
  localparam logic [OP_W-1:0] OP_LW    = 6'h23;
  localparam logic [OP_W-1:0] OP_SW    = 6'h2B;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'h04;
  localparam logic [OP_W-1:0] OP_BNE   = 6'h05;
  localparam logic [OP_W-1:0] OP_J     = 6'h02;

  localparam logic [1:0] SRCB_RT      = 2'd0;
  localparam logic [1:0] SRCB_FOUR    = 2'd1;
  localparam logic [1:0] SRCB_IMM     = 2'd2;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'd3;

  localparam logic [1:0] ALUOP_ADD   = 2'd0;
  localparam logic [1:0] ALUOP_SUB   = 2'd1;
  localparam logic [1:0] ALUOP_FUNCT = 2'd2;

  localparam logic [1:0] PCSRC_ALU    = 2'd0;
  localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
  localparam logic [1:0] PCSRC_JUMP   = 2'd2;

endpackage

// File: rtl/mips_mc_ctrl.sv
// Multi-cycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback
// and counts retired instructions.
module mips_mc_ctrl
  import mips_mc_ctrl_pkg::*;
#(
  parameter logic [5:0]  HALT_OP = 6'h3F,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_rd,
  output logic             mem_we,
  output logic             ir_we,
  output logic             pc_we,
  output logic             reg_we,
  output logic             iord,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic [1:0]       pc_src,
  output logic             done,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] retired
);

  state_e           state_q, state_d;
  logic             retire_c;
  logic [CNT_W-1:0] retired_q;

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  // Next state, plus a strobe on the last cycle of every completed instruction.
  always_comb begin
    state_d  = state_q;
    retire_c = 1'b0;
    case (state_q)
      S_FETCH:    if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_RTYPE:     state_d = S_EXEC_R;
          OP_ADDI:      state_d = S_EXEC_I;
          OP_LW, OP_SW: state_d = S_MEM_ADDR;
          OP_BEQ, OP_BNE: state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          default: begin
            if (opcode == HALT_OP) begin
              state_d = S_HALT;
            end else begin
              state_d  = S_FETCH;
              retire_c = 1'b1;
            end
          end
        endcase
      end
      S_EXEC_R:   state_d = S_WB_R;
      S_EXEC_I:   state_d = S_WB_I;
      S_MEM_ADDR: state_d = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:   if (mem_ready) state_d = S_WB_MEM;
      S_MEM_WR: begin
        if (mem_ready) begin
          state_d  = S_FETCH;
          retire_c = 1'b1;
        end
      end
      S_WB_R, S_WB_I, S_WB_MEM, S_BRANCH, S_JUMP: begin
        state_d  = S_FETCH;
        retire_c = 1'b1;
      end
      S_HALT:     state_d = S_HALT;
      default:    state_d = S_FETCH;
    endcase
  end

  // Output decode; reset forces every enable and memory request low.
  always_comb begin
    mem_rd     = 1'b0;
    mem_we     = 1'b0;
    ir_we      = 1'b0;
    pc_we      = 1'b0;
    reg_we     = 1'b0;
    iord       = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_RT;
    alu_op     = ALUOP_ADD;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    pc_src     = PCSRC_ALU;
    done       = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_rd    = 1'b1;
        alu_src_b = SRCB_FOUR;
        ir_we     = mem_ready;
        pc_we     = mem_ready;
      end
      S_DECODE:   alu_src_b = SRCB_IMM_SH2;
      S_EXEC_R: begin
        alu_src_a = 1'b1;
        alu_op    = ALUOP_FUNCT;
      end
      S_EXEC_I, S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
      end
      S_MEM_RD: begin
        mem_rd = 1'b1;
        iord   = 1'b1;
      end
      S_MEM_WR: begin
        mem_we = 1'b1;
        iord   = 1'b1;
      end
      S_WB_R: begin
        reg_we  = 1'b1;
        reg_dst = 1'b1;
      end
      S_WB_I:     reg_we = 1'b1;
      S_WB_MEM: begin
        reg_we     = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = ALUOP_SUB;
        pc_src    = PCSRC_ALUOUT;
        pc_we     = (opcode == OP_BNE) ? ~zero : zero;
      end
      S_JUMP: begin
        pc_we  = 1'b1;
        pc_src = PCSRC_JUMP;
      end
      S_HALT:     done = 1'b1;
      default:    done = 1'b0;
    endcase
    if (rst) begin
      mem_rd = 1'b0;
      mem_we = 1'b0;
      ir_we  = 1'b0;
      pc_we  = 1'b0;
      reg_we = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)           retired_q <= '0;
    else if (retire_c) retired_q <= retired_q + CNT_W'(1);
  end

  assign retired = retired_q;
  assign state   = 4'(state_q);

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// Bench for mips_mc_ctrl: per-instruction control-word recipes checked every cycle.
module tb_mips_mc_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  opcode;
  logic        zero;
  logic        mem_ready;
  logic        mem_rd, mem_we, ir_we, pc_we, reg_we, iord, alu_src_a;
  logic [1:0]  alu_src_b, alu_op, pc_src;
  logic        reg_dst, mem_to_reg, done;
  logic [3:0]  state;
  logic [15:0] retired;

  mips_mc_ctrl #(.HALT_OP(6'h3F), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .mem_rd(mem_rd), .mem_we(mem_we), .ir_we(ir_we), .pc_we(pc_we), .reg_we(reg_we),
    .iord(iord), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .pc_src(pc_src), .done(done),
    .state(state), .retired(retired)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] st;
    logic       mem_rd, mem_we, ir_we, pc_we, reg_we, iord, src_a;
    logic [1:0] src_b, alu_op;
    logic       reg_dst, m2r;
    logic [1:0] pc_src;
    logic       done;
  } ctl_t;

  localparam int K_FETCH = 0, K_DECODE = 1, K_EXEC_R = 2, K_EXEC_I = 3, K_MEM_ADDR = 4,
                 K_MEM_RD = 5, K_MEM_WR = 6, K_WB_R = 7, K_WB_I = 8, K_WB_MEM = 9,
                 K_BRANCH = 10, K_JUMP = 11, K_HALT = 12;

  int          checks = 0;
  int          errors = 0;
  ctl_t        exp_c;
  logic [15:0] exp_ret;
  logic        exp_valid = 1'b0;
  logic [15:0] model_ret = '0;
  int          n_rd_iord = 0;
  int          n_wb_mem = 0;
  ctl_t        rc[$];
  logic        rq[$];

  // Control word for one micro-step; f is the mem-complete / branch-taken qualifier.
  function automatic ctl_t cw(input int k, input logic f);
    ctl_t c;
    c = '0;
    c.st = 4'(k);
    case (k)
      K_FETCH:    begin c.mem_rd = 1'b1; c.src_b = 2'd1; c.ir_we = f; c.pc_we = f; end
      K_DECODE:   c.src_b = 2'd3;
      K_EXEC_R:   begin c.src_a = 1'b1; c.alu_op = 2'd2; end
      K_EXEC_I, K_MEM_ADDR: begin c.src_a = 1'b1; c.src_b = 2'd2; end
      K_MEM_RD:   begin c.mem_rd = 1'b1; c.iord = 1'b1; end
      K_MEM_WR:   begin c.mem_we = 1'b1; c.iord = 1'b1; end
      K_WB_R:     begin c.reg_we = 1'b1; c.reg_dst = 1'b1; end
      K_WB_I:     c.reg_we = 1'b1;
      K_WB_MEM:   begin c.reg_we = 1'b1; c.m2r = 1'b1; end
      K_BRANCH:   begin c.src_a = 1'b1; c.alu_op = 2'd1; c.pc_src = 2'd1; c.pc_we = f; end
      K_JUMP:     begin c.pc_we = 1'b1; c.pc_src = 2'd2; end
      K_HALT:     c.done = 1'b1;
      default:    c = '0;
    endcase
    return c;
  endfunction

  task automatic push(input ctl_t c, input logic r);
    rc.push_back(c);
    rq.push_back(r);
  endtask

  // Expand one instruction into its cycle-by-cycle recipe.
  task automatic build(input logic [5:0] op, input logic z, input int fw, input int mw,
                       input int halt_n);
    rc.delete();
    rq.delete();
    for (int i = 0; i < fw; i++) push(cw(K_FETCH, 1'b0), 1'b0);
    push(cw(K_FETCH, 1'b1), 1'b1);
    push(cw(K_DECODE, 1'b0), 1'b1);
    case (op)
      6'h00: begin push(cw(K_EXEC_R, 1'b0), 1'b1); push(cw(K_WB_R, 1'b0), 1'b1); end
      6'h08: begin push(cw(K_EXEC_I, 1'b0), 1'b1); push(cw(K_WB_I, 1'b0), 1'b1); end
      6'h23: begin
        push(cw(K_MEM_ADDR, 1'b0), 1'b1);
        for (int i = 0; i < mw; i++) push(cw(K_MEM_RD, 1'b0), 1'b0);
        push(cw(K_MEM_RD, 1'b0), 1'b1);
        push(cw(K_WB_MEM, 1'b0), 1'b1);
      end
      6'h2B: begin
        push(cw(K_MEM_ADDR, 1'b0), 1'b1);
        for (int i = 0; i < mw; i++) push(cw(K_MEM_WR, 1'b0), 1'b0);
        push(cw(K_MEM_WR, 1'b0), 1'b1);
      end
      6'h04: push(cw(K_BRANCH, z), 1'b1);
      6'h05: push(cw(K_BRANCH, ~z), 1'b1);
      6'h02: push(cw(K_JUMP, 1'b0), 1'b1);
      6'h3F: for (int i = 0; i < halt_n; i++) push(cw(K_HALT, 1'b0), 1'b1);
      default: ;
    endcase
  endtask

  task automatic play(input logic [5:0] op, input logic z, input int n_max);
    int n;
    n = 0;
    for (int i = 0; i < rc.size() && i < n_max; i++) begin
      @(negedge clk);
      rst = 1'b0; opcode = op; zero = z; mem_ready = rq[i];
      exp_c = rc[i]; exp_ret = model_ret; exp_valid = 1'b1;
      n++;
    end
    if (n == rc.size() && op != 6'h3F) model_ret = model_ret + 16'd1;
  endtask

  task automatic run(input logic [5:0] op, input logic z, input int fw, input int mw,
                     input int halt_n);
    build(op, z, fw, mw, halt_n);
    play(op, z, 1000);
  endtask

  task automatic do_reset(input ctl_t w);
    @(negedge clk);
    rst = 1'b1; mem_ready = 1'b0;
    exp_c = w; exp_ret = model_ret; exp_valid = 1'b1;
    model_ret = '0;
  endtask

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, expv);
    end
  endtask

  task automatic after_edge_chk(input string name, input int expv);
    @(posedge clk);
    #1;
    chk(name, int'(retired), expv);
  endtask

  // Every-cycle comparison of all outputs against the current recipe step.
  always @(negedge clk) begin
    ctl_t obs;
    #2;
    if (exp_valid) begin
      obs = {state, mem_rd, mem_we, ir_we, pc_we, reg_we, iord, alu_src_a, alu_src_b,
             alu_op, reg_dst, mem_to_reg, pc_src, done};
      checks++;
      if (obs !== exp_c) begin
        errors++;
        $display("FAIL ctl t=%0t actual=%h expected=%h", $time, obs, exp_c);
      end
      checks++;
      if (retired !== exp_ret) begin
        errors++;
        $display("FAIL retired t=%0t actual=%0d expected=%0d", $time, retired, exp_ret);
      end
      if (mem_rd && iord) n_rd_iord++;
      if (reg_we && mem_to_reg) n_wb_mem++;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    ctl_t w;
    rst = 1'b1; opcode = '0; zero = 1'b0; mem_ready = 1'b0;
    @(negedge clk);
    w = cw(K_FETCH, 1'b0); w.mem_rd = 1'b0;
    do_reset(w);

    run(6'h00, 1'b0, 0, 0, 0);
    chk("add_len", rc.size(), 4);
    after_edge_chk("add_retired", 1);

    n_rd_iord = 0; n_wb_mem = 0;
    run(6'h23, 1'b0, 0, 2, 0);
    chk("lw_len", rc.size(), 7);
    after_edge_chk("lw_retired", 2);
    chk("lw_rd_iord_cycles", n_rd_iord, 3);
    chk("lw_wb_pulses", n_wb_mem, 1);

    run(6'h04, 1'b1, 0, 0, 0);
    chk("beq_len", rc.size(), 3);
    run(6'h05, 1'b1, 0, 0, 0);
    after_edge_chk("branch_retired", 4);

    run(6'h08, 1'b0, 0, 0, 0);
    run(6'h2B, 1'b0, 1, 0, 0);
    chk("sw_fetchwait_len", rc.size(), 5);
    run(6'h02, 1'b0, 0, 0, 0);
    run(6'h3A, 1'b0, 0, 0, 0);
    chk("nop_len", rc.size(), 2);
    run(6'h04, 1'b0, 0, 0, 0);
    run(6'h05, 1'b0, 0, 0, 0);
    after_edge_chk("pre_halt_retired", 10);

    run(6'h3F, 1'b0, 0, 0, 20);
    after_edge_chk("halt_retired", 10);
    chk("halt_done", int'(done), 1);

    do_reset(cw(K_HALT, 1'b0));
    after_edge_chk("reset_from_halt_retired", 0);
    chk("reset_from_halt_done", int'(done), 0);

    // sw stalled in MEM_WR, then reset lands mid-wait.
    build(6'h2B, 1'b0, 0, 3, 0);
    play(6'h2B, 1'b0, 4);
    w = cw(K_MEM_WR, 1'b0); w.mem_we = 1'b0;
    do_reset(w);
    after_edge_chk("memwr_reset_retired", 0);
    chk("memwr_reset_state", int'(state), 0);

    run(6'h00, 1'b0, 0, 0, 0);
    after_edge_chk("post_reset_add_retired", 1);

    exp_valid = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mips_mc_ctrl.md
MIPS_MC_CTRL -- requirements
Module: mips_mc_ctrl

Interface
REQ-001 Parameter: HALT_OP, 6'h3F, opcode that stops the processor.
REQ-002 Parameter: CNT_W, 16, width of the retired-instruction counter.
REQ-003 Port: clk  in  1  single system clock; all state changes on posedge clk.
REQ-004 Port: rst  in  1  reset, synchronous and active-high.
REQ-005 Port: opcode  in  6  IR[31:26], valid from DECODE onward.
REQ-006 Port: zero  in  1  ALU zero flag, combinational from the current ALU operands.
REQ-007 Port: mem_ready  in  1  memory handshake; completes the current mem_rd/mem_we request.
REQ-008 Port: mem_rd, mem_we  out  1 each  memory read / write request, held until mem_ready.
REQ-009 Port: ir_we, pc_we, reg_we  out  1 each  IR, PC and register-file write enables.
REQ-010 Port: iord  out  1  memory address select: 0 = PC, 1 = ALUOut.
REQ-011 Port: alu_src_a  out  1  ALU A select: 0 = PC, 1 = rs.
REQ-012 Port: alu_src_b  out  2  ALU B select: 0 = rt, 1 = const 4, 2 = sign-extended imm, 3 = sign-extended imm << 2.
REQ-013 Port: alu_op  out  2  ALU operation: 0 = add, 1 = sub, 2 = use funct field.
REQ-014 Port: reg_dst, mem_to_reg  out  1 each  write-register select (1 = rd); write-data select (1 = MDR).
REQ-015 Port: pc_src  out  2  next-PC select: 0 = ALU result, 1 = ALUOut, 2 = jump target.
REQ-016 Port: done  out  1  sticky halt indication.
REQ-017 Port: state  out  4  current state encoding, for debug.
REQ-018 Port: retired  out  CNT_W  count of completed instructions.

Function
REQ-019 FSM states: FETCH, DECODE, EXEC_R, EXEC_I, MEM_ADDR, MEM_RD, MEM_WR, WB_R, WB_I, WB_MEM, BRANCH, JUMP, HALT.
REQ-020 Moore outputs only; any output not listed for a state is 0.
REQ-021 FETCH
- mem_rd=1, iord=0, alu_src_a=0, alu_src_b=1, alu_op=0.
- When mem_ready=1: ir_we=1, pc_we=1, pc_src=0, and the next state is DECODE.
- When mem_ready=0: stay in FETCH with no write enables.
REQ-022 DECODE
- Outputs: alu_src_a=0, alu_src_b=3, alu_op=0 (branch target into ALUOut).
- Next state by opcode: 0x00 -> EXEC_R; 0x08 -> EXEC_I; 0x23 or 0x2B -> MEM_ADDR; 0x04 or 0x05 -> BRANCH; 0x02 -> JUMP; HALT_OP -> HALT.
- Any other opcode -> FETCH, counted as retired (NOP).
REQ-023 EXEC_R: alu_src_a=1, alu_src_b=0, alu_op=2; next state WB_R.
REQ-024 WB_R: reg_we=1, reg_dst=1, mem_to_reg=0; next state FETCH.
REQ-025 EXEC_I: alu_src_a=1, alu_src_b=2, alu_op=0; next state WB_I.
REQ-026 WB_I: reg_we=1, reg_dst=0, mem_to_reg=0; next state FETCH.
REQ-027 MEM_ADDR: alu_src_a=1, alu_src_b=2, alu_op=0; next state MEM_RD for 0x23, MEM_WR for 0x2B.
REQ-028 MEM_RD: mem_rd=1, iord=1; on mem_ready go to WB_MEM, otherwise hold.
REQ-029 MEM_WR: mem_we=1, iord=1; on mem_ready go to FETCH, otherwise hold.
REQ-030 WB_MEM: reg_we=1, reg_dst=0, mem_to_reg=1; next state FETCH.
REQ-031 BRANCH
- Outputs: alu_src_a=1, alu_src_b=0, alu_op=1, pc_src=1.
- pc_we = zero for 0x04 (beq); pc_we = ~zero for 0x05 (bne).
- Next state FETCH.
REQ-032 JUMP: pc_we=1, pc_src=2; next state FETCH.
REQ-033 HALT: done=1; all enables 0; stays in HALT until rst.
REQ-034 retired increments by 1 on the final cycle of each instruction, including NOPs and not-taken branches; HALT itself is not counted; the counter wraps modulo 2^CNT_W.
REQ-035 Cycle counts with zero-wait memory (mem_ready=1 on the first request cycle):
- R-type, addi, sw: 4 cycles.
- lw: 5 cycles.
- beq, bne, j: 3 cycles.
- Each extra cycle mem_ready is held low adds 1 cycle.
REQ-036 mem_ready asserted while no request is outstanding is ignored.

Reset
REQ-037 When rst=1 at a posedge, the next values are: state=FETCH, retired=0, done=0.
REQ-038 During any cycle with rst=1, all write enables and memory requests are 0, regardless of state; this also applies to reset mid-instruction or mid-wait.
REQ-039 Reset clears HALT; the first fetch request occurs in the cycle after rst deasserts.

Structure
REQ-040 The shared package holds the state enum, the opcode constants (R-type, addi, lw, sw, beq, bne, j) and the alu_src_b, alu_op and pc_src encodings.
REQ-041 No sub-module: one state register, one next-state block, one output decoder and the retired counter.

Verification
REQ-042 add (op 0x00), mem_ready=1 -> states FETCH, DECODE, EXEC_R, WB_R; reg_we=1 with reg_dst=1 in cycle 4; retired goes 0 -> 1.
REQ-043 lw (0x23), mem_ready low for 2 cycles in MEM_RD -> 7 cycles total; mem_rd=1 with iord=1 for 3 cycles; one reg_we pulse with mem_to_reg=1.
REQ-044 beq with zero=1 -> pc_we=1, pc_src=1 in cycle 3; bne with zero=1 -> pc_we=0; retired=2 after both.
REQ-045 Opcode 0x3F -> done rises in the cycle after DECODE and stays 1 for 20 cycles with no enables; retired unchanged.
REQ-046 rst pulse while in MEM_WR with mem_ready=0 -> mem_we=0 in the rst cycle; state=FETCH and retired=0 on the next cycle; no write occurs.
REQ-047 Opcode 0x3A (undefined) -> DECODE returns to FETCH; 2-cycle instruction; retired increments.
